// File: rtl/blob_pkg.sv
// Shared constants, FSM encoding and helpers for the blob centroid extractor.
package blob_pkg;

  localparam int H_MAX     = 320;
  localparam int V_MAX     = 240;
  localparam int MIN_COUNT = 16;
  localparam int DIV_W     = 25;
  localparam int CNT_W     = 17;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DONE
  } blob_state_t;

  function automatic logic [8:0] sat_pos(input logic [31:0] q);
    return (q > 32'd511) ? 9'd511 : q[8:0];
  endfunction

endpackage

// File: rtl/blob_centroid_if.sv
// Pixel-stream in / centroid-result out bundle between tracker, blob_centroid and control.
interface blob_centroid_if;
  import blob_pkg::*;

  logic             pixel_valid_in;
  logic             hit_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             frame_end_in;
  logic [8:0]       x_center_out;
  logic [8:0]       y_center_out;
  logic [CNT_W-1:0] area_out;
  logic [8:0]       radius_out;
  logic             found_out;
  logic             result_valid_out;
  logic             busy_out;
  logic             overrun_out;

  modport master (
    output pixel_valid_in, hit_in, hcount_in, vcount_in, frame_end_in,
    input  x_center_out, y_center_out, area_out, radius_out, found_out,
           result_valid_out, busy_out, overrun_out
  );

  modport slave (
    input  pixel_valid_in, hit_in, hcount_in, vcount_in, frame_end_in,
    output x_center_out, y_center_out, area_out, radius_out, found_out,
           result_valid_out, busy_out, overrun_out
  );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider: loads on start, one quotient bit per cycle, done pulses after W cycles.
module seq_divider
  import blob_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          active;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          fits;

  assign shifted = {rem, quotient[W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = shifted >= {1'b0, dvs};

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        dvs      <= divisor;
        cnt      <= CW'(W);
        active   <= 1'b1;
      end else if (active) begin
        rem      <= fits ? diff[W-1:0] : shifted[W-1:0];
        quotient <= {quotient[W-2:0], fits};
        cnt      <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/blob_centroid.sv
// Per-frame hit area and centroid extractor; optional bounding-box radius when BLOB_BBOX_EN is defined.
module blob_centroid #(
  parameter int H_MAX     = blob_pkg::H_MAX,
  parameter int V_MAX     = blob_pkg::V_MAX,
  parameter int MIN_COUNT = blob_pkg::MIN_COUNT,
  parameter int DIV_W     = blob_pkg::DIV_W
) (
  input logic            clk_in,
  input logic            rst_in,
  blob_centroid_if.slave bus
);
  import blob_pkg::blob_state_t;
  import blob_pkg::CNT_W;
  import blob_pkg::sat_pos;

  localparam int TICK_W = $clog2(DIV_W + 1);

  blob_state_t       state;
  logic [TICK_W-1:0] tick;
  logic              hit_ok;
  logic [CNT_W-1:0]  count_acc, count_next, snap_count;
  logic [DIV_W-1:0]  sum_x, sum_y, sum_x_next, sum_y_next, snap_x, snap_y;
  logic              do_div;
  logic [DIV_W-1:0]  qx;
  logic              div_start, div_done;
  logic [DIV_W-1:0]  div_quotient;
  logic [8:0]        x_q, y_q;
  logic [CNT_W-1:0]  area_q;
  logic              found_q, valid_q, busy_q, overrun_q;

  assign hit_ok = bus.pixel_valid_in && bus.hit_in &&
                  (32'(bus.hcount_in) < H_MAX) && (32'(bus.vcount_in) < V_MAX);

  // Next-sum values include the current pixel, so a hit coincident with frame end is snapshotted.
  assign count_next = count_acc + CNT_W'(hit_ok);
  assign sum_x_next = hit_ok ? sum_x + DIV_W'(bus.hcount_in) : sum_x;
  assign sum_y_next = hit_ok ? sum_y + DIV_W'(bus.vcount_in) : sum_y;

  always_ff @(posedge clk_in) begin
    if (rst_in || bus.frame_end_in) begin
      count_acc <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
    end else begin
      count_acc <= count_next;
      sum_x     <= sum_x_next;
      sum_y     <= sum_y_next;
    end
  end

  assign div_start = do_div && (tick == '0) &&
                     (state == blob_pkg::DIV_X || state == blob_pkg::DIV_Y);

  seq_divider #(.W(DIV_W)) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend ((state == blob_pkg::DIV_X) ? snap_x : snap_y),
    .divisor  (DIV_W'(snap_count)),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // Each divide state lasts DIV_W+1 cycles whether or not the divider runs, keeping latency fixed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= blob_pkg::IDLE;
      tick       <= '0;
      snap_count <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      do_div     <= 1'b0;
      qx         <= '0;
      x_q        <= '0;
      y_q        <= '0;
      area_q     <= '0;
      found_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (valid_q)
        busy_q <= 1'b0;
      if (bus.frame_end_in && state != blob_pkg::IDLE)
        overrun_q <= 1'b1;
      case (state)
        blob_pkg::IDLE: begin
          if (bus.frame_end_in) begin
            snap_count <= count_next;
            snap_x     <= sum_x_next;
            snap_y     <= sum_y_next;
            do_div     <= 32'(count_next) >= MIN_COUNT;
            tick       <= '0;
            busy_q     <= 1'b1;
            state      <= blob_pkg::DIV_X;
          end
        end
        blob_pkg::DIV_X: begin
          tick <= tick + 1'b1;
          if (tick == TICK_W'(DIV_W)) begin
            tick  <= '0;
            state <= blob_pkg::DIV_Y;
          end
        end
        blob_pkg::DIV_Y: begin
          if (div_done)
            qx <= div_quotient;
          tick <= tick + 1'b1;
          if (tick == TICK_W'(DIV_W)) begin
            tick  <= '0;
            state <= blob_pkg::DONE;
          end
        end
        blob_pkg::DONE: begin
          area_q  <= snap_count;
          found_q <= do_div;
          if (do_div) begin
            x_q <= sat_pos(32'(qx));
            y_q <= sat_pos(32'(div_quotient));
          end
          valid_q <= 1'b1;
          state   <= blob_pkg::IDLE;
        end
        default: state <= blob_pkg::IDLE;
      endcase
    end
  end

`ifdef BLOB_BBOX_EN
  logic [10:0] min_x, max_x, min_x_nx, max_x_nx, snap_min_x, snap_max_x;
  logic [9:0]  min_y, max_y, min_y_nx, max_y_nx, snap_min_y, snap_max_y;
  logic [11:0] bbox_sum;
  logic [8:0]  radius_q;

  always_comb begin
    min_x_nx = min_x;
    max_x_nx = max_x;
    min_y_nx = min_y;
    max_y_nx = max_y;
    if (hit_ok) begin
      if (bus.hcount_in < min_x) min_x_nx = bus.hcount_in;
      if (bus.hcount_in > max_x) max_x_nx = bus.hcount_in;
      if (bus.vcount_in < min_y) min_y_nx = bus.vcount_in;
      if (bus.vcount_in > max_y) max_y_nx = bus.vcount_in;
    end
  end

  assign bbox_sum = {1'b0, snap_max_x - snap_min_x} + {2'b0, snap_max_y - snap_min_y};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      min_x      <= '1;
      max_x      <= '0;
      min_y      <= '1;
      max_y      <= '0;
      snap_min_x <= '0;
      snap_max_x <= '0;
      snap_min_y <= '0;
      snap_max_y <= '0;
      radius_q   <= '0;
    end else begin
      if (bus.frame_end_in) begin
        min_x <= '1;
        max_x <= '0;
        min_y <= '1;
        max_y <= '0;
        if (state == blob_pkg::IDLE) begin
          snap_min_x <= min_x_nx;
          snap_max_x <= max_x_nx;
          snap_min_y <= min_y_nx;
          snap_max_y <= max_y_nx;
        end
      end else begin
        min_x <= min_x_nx;
        max_x <= max_x_nx;
        min_y <= min_y_nx;
        max_y <= max_y_nx;
      end
      if (state == blob_pkg::DONE && do_div)
        radius_q <= 9'(bbox_sum >> 2);
    end
  end

  assign bus.radius_out = radius_q;
`else
  assign bus.radius_out = '0;
`endif

  assign bus.x_center_out     = x_q;
  assign bus.y_center_out     = y_q;
  assign bus.area_out         = area_q;
  assign bus.found_out        = found_q;
  assign bus.result_valid_out = valid_q;
  assign bus.busy_out         = busy_q;
  assign bus.overrun_out      = overrun_q;

endmodule

// File: tb/tb_blob_centroid.sv
// Self-checking bench for blob_centroid: directed frames plus randomized clusters against an arithmetic model.
module tb_blob_centroid;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  blob_centroid_if bus ();

  blob_centroid dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int compared_count   = 0;
  int mismatched_count = 0;

  // Reference model: running frame totals and the expected visible outputs.
  longint m_count, m_sx, m_sy;
  int     m_minx, m_maxx, m_miny, m_maxy;
  bit     m_busy, m_overrun;
  int     e_area, e_x, e_y, e_r;
  bit     e_found;

  task automatic clear_frame();
    m_count = 0; m_sx = 0; m_sy = 0;
    m_minx = 1 << 30; m_maxx = -1; m_miny = 1 << 30; m_maxy = -1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared_count++;
    assert (obs === exp) else begin
      mismatched_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit valid, input bit hit, input int h, input int v, input bit fe);
    bus.pixel_valid_in = valid;
    bus.hit_in         = hit;
    bus.hcount_in      = 11'(h);
    bus.vcount_in      = 10'(v);
    bus.frame_end_in   = fe;
    if (valid && hit && h < 320 && v < 240) begin
      m_count++; m_sx += h; m_sy += v;
      if (h < m_minx) m_minx = h;
      if (h > m_maxx) m_maxx = h;
      if (v < m_miny) m_miny = v;
      if (v > m_maxy) m_maxy = v;
    end
    if (fe) begin
      if (m_busy) m_overrun = 1'b1;
      else begin
        m_busy = 1'b1;
        e_area = int'(m_count);
        e_found = (m_count >= 16);
        if (e_found) begin
          e_x = (m_sx / m_count > 511) ? 511 : int'(m_sx / m_count);
          e_y = (m_sy / m_count > 511) ? 511 : int'(m_sy / m_count);
`ifdef BLOB_BBOX_EN
          e_r = ((m_maxx - m_minx) + (m_maxy - m_miny)) / 4;
`endif
        end
      end
      clear_frame();
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 0, 0, 0);
  endtask

  task automatic check_state(input string tag);
    check_output({tag, " x"}, 32'(bus.x_center_out), e_x);
    check_output({tag, " y"}, 32'(bus.y_center_out), e_y);
    check_output({tag, " area"}, 32'(bus.area_out), e_area);
    check_output({tag, " radius"}, 32'(bus.radius_out), e_r);
    check_output({tag, " found"}, 32'(bus.found_out), 32'(e_found));
    check_output({tag, " overrun"}, 32'(bus.overrun_out), 32'(m_overrun));
  endtask

  // Called just after the frame_end edge plus 'elapsed' further edges.
  task automatic wait_result(input string tag, input int elapsed);
    int lat = elapsed;
    check_output({tag, " busy"}, 32'(bus.busy_out), 1);
    while (!bus.result_valid_out && lat < 150) begin
      idle(1);
      lat++;
    end
    check_output({tag, " latency"}, lat, 53);
    check_state(tag);
    check_output({tag, " busy at result"}, 32'(bus.busy_out), 1);
    m_busy = 1'b0;
    idle(1);
    check_output({tag, " pulse width"}, 32'(bus.result_valid_out), 0);
    check_output({tag, " busy after"}, 32'(bus.busy_out), 0);
  endtask

  task automatic count_pulses(input string tag, input int n);
    int pulses = 0;
    repeat (n) begin
      idle(1);
      if (bus.result_valid_out) pulses++;
    end
    check_output({tag, " extra pulses"}, pulses, 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    clear_frame();
    m_busy = 0; m_overrun = 0;
    e_area = 0; e_x = 0; e_y = 0; e_r = 0; e_found = 0;
  endtask

  task automatic random_cluster(input int n, input int hits_max);
    int cx = int'($urandom_range(20, 300));
    int cy = int'($urandom_range(20, 230));
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      bit hit = ($urandom_range(0, 1) == 1) && (hits < hits_max);
      if (hit) hits++;
      apply_stimulus($urandom_range(0, 3) != 0, hit,
                     cx + int'($urandom_range(0, 40)) - 20,
                     cy + int'($urandom_range(0, 40)) - 20, 0);
    end
  endtask

  initial begin
    $display("[TB] blob_centroid bench start");
    rst_in = 1'b1;
    bus.pixel_valid_in = 0; bus.hit_in = 0; bus.hcount_in = 0;
    bus.vcount_in = 0; bus.frame_end_in = 0;
    idle(1);
    do_reset();
    check_state("reset");
    check_output("reset busy", 32'(bus.busy_out), 0);
    check_output("reset valid", 32'(bus.result_valid_out), 0);

    // 4x4 square with some non-hit pixels around it
    for (int v = 49; v < 55; v++)
      for (int h = 99; h < 105; h++)
        apply_stimulus(1, (h >= 100 && h <= 103 && v >= 50 && v <= 53), h, v, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    wait_result("square", 0);

    for (int h = 0; h < 30; h++) apply_stimulus(1, 0, h, 10, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    wait_result("empty", 0);

    for (int v = 0; v < 240; v++)
      for (int h = 0; h < 320; h++)
        apply_stimulus(1, 1, h, v, 0);
    apply_stimulus(1, 1, 400, 300, 1);
    wait_result("full", 0);

    for (int i = 0; i < 15; i++) apply_stimulus(1, 1, 5, 5, 0);
    apply_stimulus(1, 1, 5, 5, 1);
    wait_result("coincident", 0);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 200, 100, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    wait_result("after coincident", 0);

    for (int i = 0; i < 20; i++) apply_stimulus(1, 1, 60 + i % 5, 70 + i / 5, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    idle(9);
    apply_stimulus(1, 1, 10, 10, 1);
    wait_result("overrun", 10);
    count_pulses("overrun", 60);
    check_output("overrun sticky", 32'(bus.overrun_out), 1);

    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 30, 40, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    idle(20);
    do_reset();
    check_state("mid reset");
    check_output("mid reset busy", 32'(bus.busy_out), 0);
    check_output("mid reset valid", 32'(bus.result_valid_out), 0);
    count_pulses("mid reset", 60);

    for (int f = 0; f < 3; f++) begin
      random_cluster(int'($urandom_range(150, 300)), 1000);
      apply_stimulus(1, $urandom_range(0, 1) == 1, 150, 120, 1);
      wait_result($sformatf("random %0d", f), 0);
    end
    random_cluster(60, 10);
    apply_stimulus(0, 0, 0, 0, 1);
    wait_result("random sparse", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatched_count);
    $finish;
  end

endmodule

// File: doc/blob_centroid.md
Name: blob_centroid

Overview:
- Per-frame centroid/area extractor for the thresholded tracking mask.
- Consumes the per-pixel "hit" stream (pixel matches goal colour) alongside the display scan counters.
- Accumulates hit count and coordinate sums over a frame; at frame end, divides sequentially to produce x/y centre and area.
- Feeds cur_pos_x / cur_pos_y / cur_rad of the control and initialize stages; sits between the thresholding tracker and control.

Parameters:
- H_MAX, 320, active columns; hits with hcount_in >= H_MAX are ignored.
- V_MAX, 240, active rows; hits with vcount_in >= V_MAX are ignored.
- MIN_COUNT, 16, minimum hit count for found_out=1.
- DIV_W, 25, sum/dividend width; must hold H_MAX*H_MAX*V_MAX.

Ports:
- clk_in  in  1  system clock (65 MHz pixel clock domain).
- rst_in  in  1  synchronous active-high reset.
- pixel_valid_in  in  1  current hcount/vcount/hit sample is valid.
- hit_in  in  1  pixel passes colour threshold.
- hcount_in  in  11  pixel column.
- vcount_in  in  10  pixel row.
- frame_end_in  in  1  one-cycle pulse closing the current frame.
- x_center_out  out  9  centroid column, floor(sum_x/count).
- y_center_out  out  9  centroid row, floor(sum_y/count).
- area_out  out  17  hit count of the last completed frame.
- radius_out  out  9  bounding-box radius (0 when BLOB_BBOX_EN is off).
- found_out  out  1  last frame had count >= MIN_COUNT.
- result_valid_out  out  1  one-cycle pulse when outputs update.
- busy_out  out  1  divider running.
- overrun_out  out  1  sticky: frame_end_in arrived while busy; cleared only by reset.

Behaviour:
- Reset: all outputs 0; accumulators 0; FSM to IDLE. Applies mid-division; an in-flight result is discarded and no result_valid_out pulse is issued.
- Accumulate every cycle: if pixel_valid_in && hit_in && hcount_in<H_MAX && vcount_in<V_MAX, then count+=1, sum_x+=hcount_in, sum_y+=vcount_in.
- Frame end while IDLE:
  - Snapshot count/sum_x/sum_y, including a hit in the same cycle.
  - Clear the accumulators the same edge, so the next frame starts clean.
  - FSM goes IDLE->DIV_X.
- Frame end while busy: the snapshot is skipped. Accumulators still clear, the closing frame is dropped, overrun_out=1.
- FSM states:
  - IDLE -> DIV_X (on frame end).
  - DIV_X: DIV_W-iteration restoring divide sum_x/count; the x quotient is kept until the Y divide completes.
  - DIV_Y: same for sum_y.
  - DONE: register outputs, pulse result_valid_out.
  - DONE -> IDLE.
- Latency: result_valid_out asserts exactly 2*DIV_W+3 = 53 cycles after the edge sampling frame_end_in. busy_out=1 from the cycle after that edge through the result_valid_out cycle.
- Snapshot count < MIN_COUNT (including 0):
  - Division is skipped; divide-by-zero is never started.
  - The FSM still waits through DIV_X/DIV_Y so latency stays fixed.
  - found_out=0; x_center_out, y_center_out and radius_out hold their previous values; area_out updates.
- Quotients truncate (floor) and saturate to 9 bits; sums never wrap given DIV_W.

Optional Feature:
- BLOB_BBOX_EN defined:
  - Track min_x/max_x/min_y/max_y of hits, reset per frame.
  - radius_out = ((max_x-min_x)+(max_y-min_y))>>2, updated in DONE under the same found_out rule.
- BLOB_BBOX_EN undefined: no bbox logic; radius_out tied 0.

Decomposition:
- Shared package blob_pkg:
  - FSM enum (IDLE, DIV_X, DIV_Y, DONE).
  - Defaults H_MAX, V_MAX, DIV_W, MIN_COUNT.
- Sub-module seq_divider (start/done handshake, DIV_W-bit restoring unsigned divider), instantiated once and reused for X then Y.

Test Plan:
- 4x4 hit square at x 100..103, y 50..53, then frame_end -> 53 cycles later: area 16, x 101, y 51, found 1, one result pulse; with BLOB_BBOX_EN, radius 1.
- Frame with zero hits -> area 0, found 0, centres hold prior values (101/51), latency still 53.
- Every pixel of 320x240 a hit -> area 76800, x 159, y 119, found 1.
- Hit coincident with frame_end_in at (5,5) after 15 prior hits at (5,5) -> counted: area 16, x 5, y 5; next frame's accumulators start at 0.
- Second frame_end 10 cycles after first -> second ignored, overrun_out=1, exactly one result_valid pulse.
- rst_in pulsed 20 cycles into a division -> no result_valid pulse; all outputs 0; next frame computes normally.
